uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer placed directly upstream of the UART transmitter.
- Accepts bytes from a host over a valid/ready handshake and stores them in a circular FIFO.
- Feeds the transmitter's tx_data/tx_start interface one byte at a time, waiting for tx_busy/tx_done before launching the next byte.
- Lets software queue bursts without polling tx_busy per byte.

Parameters:
- DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
- ACK_TIMEOUT, 8, clock cycles allowed after a tx_start pulse for tx_busy to rise before the launch is declared failed.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  1  host presents a byte.
- wr_data  input  8  host byte.
- wr_ready  output  1  FIFO can accept; equals !full, from registered state.
- flush  input  1  synchronous FIFO clear; an in-flight byte is not aborted.
- tx_busy  input  1  from transmitter: frame in progress.
- tx_done  input  1  from transmitter: one-cycle end-of-frame pulse.
- tx_data  output  8  byte to transmitter; registered.
- tx_start  output  1  one-cycle launch pulse to transmitter; registered.
- count  output  $clog2(DEPTH+1)  entries currently stored.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ack_err  output  1  sticky: a launch timed out; cleared only by reset.

Behaviour:
- Reset values:
  - wr_ready = 1, tx_data = 8'h00, tx_start = 0, count = 0, empty = 1, full = 0, ack_err = 0.
  - Read and write pointers = 0; FSM = IDLE; timeout counter = 0.
- Reset asserted mid-frame: all of the above apply on the next edge and stored bytes are discarded. The transmitter is reset by the same signal.
- Storage:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately and is the sole source of full/empty.
- Push: occurs on an edge where wr_valid && wr_ready. wr_data is written at wr_ptr, wr_ptr increments, count increments.
- Push when full: wr_ready = 0, so nothing is written. Data held by the host is not lost; the host must hold wr_valid.
- Pop: performed only by the FSM in IDLE. Head byte goes to the tx_data register, rd_ptr increments, count decrements.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Push into empty FIFO: the byte is visible to the FSM on the next edge, so tx_start rises on the first edge after the accepting edge.
- Flush:
  - On an edge with flush = 1: pointers = 0 and count = 0; any push in that same cycle is dropped.
  - The FSM, tx_data and any frame in progress are unaffected.
- FSM states:
  - IDLE:
    - tx_start = 0.
    - If !empty && !tx_busy && !flush: pop, load tx_data, tx_start <= 1, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK:
    - tx_start = 0 after its single cycle.
    - If tx_busy = 1: go to WAIT_DONE.
    - Otherwise increment the timeout counter. When the counter reaches ACK_TIMEOUT-1: set ack_err = 1 and go to IDLE; the byte is considered lost.
  - WAIT_DONE:
    - If tx_done = 1, or tx_busy = 0: go to IDLE.
    - The next launch is possible on the following edge at the earliest.
- tx_data holds its value from the launch until the next pop; it never changes while tx_busy = 1.
- tx_start is never high for two consecutive cycles and is never asserted outside IDLE→WAIT_ACK.
- tx_done seen in IDLE or WAIT_ACK is ignored.
- tx_busy already high in IDLE (transmitter owned elsewhere) blocks launch indefinitely, with no error.

Test Plan:
1. Reset, then push 8'hA5 into an empty FIFO with tx_busy low → tx_start high for exactly 1 cycle on the first edge after the push, tx_data = 8'hA5, count returns to 0. A transmitter model raising tx_busy 1 cycle later, then pulsing tx_done, returns the FSM to IDLE.
2. Burst-push DEPTH+2 bytes (0x00..0x11) with tx_busy held high → wr_ready drops after 16 accepted, full = 1, count = 16. Releasing tx_busy drains bytes in order 0x00..0x0F. The host's held byte 0x10 is accepted once the first pop frees a slot.
3. Push and pop in the same cycle with count = 5 → count stays 5; pointer wrap across entry 15→0 preserves order over 40 bytes.
4. After a tx_start, hold tx_busy low → ack_err rises ACK_TIMEOUT cycles after tx_start and stays high; the next byte launches normally.
5. Assert flush with count = 7 while a frame is in WAIT_DONE → count = 0 and empty = 1 next cycle; the in-flight frame completes and tx_data is unchanged.
6. Assert reset in WAIT_DONE with count = 3 → next cycle count = 0, tx_start = 0, tx_data = 0, ack_err = 0, FSM in IDLE.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter one byte at a time.
// Host pushes over valid/ready; an FSM launches each byte and waits for the frame to finish.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          empty_r;
    logic          full_r;
    logic          wr_ready_r;
    state_t        state_r;
    logic [TW-1:0] tmo_r;
    logic [7:0]    tx_data_r;
    logic          tx_start_r;
    logic          ack_err_r;
    logic          push_s;
    logic          pop_s;

    // Flush wins over a same-cycle push and also blocks a launch that cycle.
    assign push_s = wr_valid && wr_ready_r && !flush;
    assign pop_s  = (state_r == IDLE) && !empty_r && !tx_busy && !flush;

    // Next occupancy; status flags are registered from this value.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1'b1);
                2'b01:   count_next_s = count_r - CW'(1'b1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Storage array write port; contents are meaningless once pointers reset.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the flags derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
            end
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == {CW{1'b0}});
            full_r     <= (count_next_s == DEPTH_C);
            wr_ready_r <= (count_next_s != DEPTH_C);
        end
    end

    // Launch FSM: pop and pulse tx_start, wait for busy, then wait for frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tmo_r      <= {TW{1'b0}};
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            ack_err_r  <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        tx_data_r  <= mem_r[rd_ptr_r];
                        tx_start_r <= 1'b1;
                        tmo_r      <= {TW{1'b0}};
                        state_r    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_r <= WAIT_DONE;
                    end else if (tmo_r == TMO_LAST) begin
                        // Transmitter never acknowledged; the byte is dropped.
                        ack_err_r <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        tmo_r <= tmo_r + TW'(1'b1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_done || !tx_busy) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign wr_ready = wr_ready_r;
    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign ack_err  = ack_err_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model that records launched bytes.
module tb_uart_tx_fifo;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       ack_err;

    logic       manual_busy = 1'b0;
    logic       model_en = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_cnt = 8'd0;
    int         frame_len = 3;
    logic [7:0] rx_q[$];

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_data(tx_data), .tx_start(tx_start), .count(count), .empty(empty),
        .full(full), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    assign tx_busy = manual_busy | (model_en & m_busy);
    assign tx_done = model_en & m_done;

    // Transmitter model: busy the edge after tx_start, done pulse on the last busy cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 8'd0;
        end else if (m_busy) begin
            if (m_cnt > 8'd1) begin
                m_cnt <= m_cnt - 8'd1;
            end else if (m_cnt == 8'd1) begin
                m_done <= 1'b1;
                m_cnt  <= 8'd0;
            end else begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end else if (model_en && tx_start) begin
            m_busy <= 1'b1;
            m_cnt  <= frame_len[7:0];
            rx_q.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (rx_q.size() == n && tx_busy == 1'b0 && empty == 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks += 7;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int base;
        bit ok;
        base = rx_q.size();
        model_en = 1'b1;
        wr_data = 8'hA5;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        n_checks += 2;
        if (count !== 5'd1) begin n_fail++; $display("FAIL single_count_after_push: got %0d expected 1", count); end
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b expected 0", tx_start); end
        tick();
        n_checks += 3;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", tx_data); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
        tick();
        n_checks++;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b expected 0", tx_start); end
        wait_drain(base + 1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout expected frame end"); end
        else begin
            n_checks++;
            if (rx_q[base] !== 8'hA5) begin n_fail++; $display("FAIL single_rx: got %h expected a5", rx_q[base]); end
        end
    endtask

    task automatic test_burst();
        int base;
        bit ok;
        base = rx_q.size();
        manual_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(i);
            wr_valid = 1'b1;
            n_checks++;
            if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready_%0d: got %b expected 1", i, wr_ready); end
            tick();
        end
        wr_data = 8'h10;
        n_checks += 3;
        if (full !== 1'b1) begin n_fail++; $display("FAIL burst_full: got %b expected 1", full); end
        if (count !== 5'd16) begin n_fail++; $display("FAIL burst_count: got %0d expected 16", count); end
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready_full: got %b expected 0", wr_ready); end
        tick();
        tick();
        tick();
        n_checks++;
        if (count !== 5'd16) begin n_fail++; $display("FAIL burst_held: got %0d expected 16", count); end
        manual_busy = 1'b0;
        tick();
        n_checks += 4;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL burst_first_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL burst_first_data: got %h expected 00", tx_data); end
        if (count !== 5'd15) begin n_fail++; $display("FAIL burst_first_pop: got %0d expected 15", count); end
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL burst_slot_free: got %b expected 1", wr_ready); end
        tick();
        n_checks++;
        if (count !== 5'd16) begin n_fail++; $display("FAIL burst_held_accept: got %0d expected 16", count); end
        wr_data = 8'h11;
        for (int k = 0; k < 200 && wr_ready !== 1'b1; k++) tick();
        tick();
        wr_valid = 1'b0;
        wait_drain(base + DEPTH + 2, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL burst_drain: got %0d bytes expected %0d", rx_q.size() - base, DEPTH + 2); end
        else begin
            for (int i = 0; i < DEPTH + 2; i++) begin
                n_checks++;
                if (rx_q[base + i] !== 8'(i)) begin n_fail++; $display("FAIL burst_order_%0d: got %h expected %h", i, rx_q[base + i], 8'(i)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = rx_q.size();
        manual_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h20 + 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        n_checks++;
        if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_prefill: got %0d expected 5", count); end
        wr_data = 8'h25;
        manual_busy = 1'b0;
        tick();
        n_checks += 3;
        if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_push_pop_count: got %0d expected 5", count); end
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h20) begin n_fail++; $display("FAIL b2b_data: got %h expected 20", tx_data); end
        for (int j = 6; j < 40; j++) begin
            wr_data = 8'h20 + 8'(j);
            for (int k = 0; k < 200 && wr_ready !== 1'b1; k++) tick();
            tick();
        end
        wr_valid = 1'b0;
        wait_drain(base + 40, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d bytes expected 40", rx_q.size() - base); end
        else begin
            for (int i = 0; i < 40; i++) begin
                n_checks++;
                if (rx_q[base + i] !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL b2b_order_%0d: got %h expected %h", i, rx_q[base + i], 8'h20 + 8'(i)); end
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        model_en = 1'b0;
        manual_busy = 1'b0;
        wr_data = 8'h55;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        n_checks += 2;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h55) begin n_fail++; $display("FAIL tmo_data: got %h expected 55", tx_data); end
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
        n_checks++;
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", ack_err); end
        tick();
        n_checks++;
        if (ack_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", ack_err); end
        tick();
        tick();
        n_checks++;
        if (ack_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", ack_err); end
        base = rx_q.size();
        model_en = 1'b1;
        wr_data = 8'h66;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        n_checks += 2;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL tmo_next_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h66) begin n_fail++; $display("FAIL tmo_next_data: got %h expected 66", tx_data); end
        wait_drain(base + 1, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL tmo_next_drain: got timeout expected frame end"); end
        if (ack_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky_after: got %b expected 1", ack_err); end
    endtask

    task automatic test_flush();
        int base;
        bit ok;
        base = rx_q.size();
        frame_len = 12;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h70 + 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        n_checks++;
        if (count !== 5'd7) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 7", count); end
        wr_data = 8'h78;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wr_valid = 1'b0;
        n_checks += 3;
        if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", empty); end
        if (tx_data !== 8'h70) begin n_fail++; $display("FAIL flush_data: got %h expected 70", tx_data); end
        wait_drain(base + 1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL flush_inflight: got %0d bytes expected 1", rx_q.size() - base); end
        tick();
        tick();
        n_checks += 3;
        if (tx_data !== 8'h70) begin n_fail++; $display("FAIL flush_data_hold: got %h expected 70", tx_data); end
        if (rx_q.size() != base + 1) begin n_fail++; $display("FAIL flush_no_relaunch: got %0d bytes expected 1", rx_q.size() - base); end
        if (count !== 5'd0) begin n_fail++; $display("FAIL flush_push_dropped: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        frame_len = 12;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h80 + 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        n_checks++;
        if (count !== 5'd3) begin n_fail++; $display("FAIL rstmid_prefill: got %0d expected 3", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks += 5;
        if (count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b expected 0", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", tx_data); end
        if (ack_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_err: got %b expected 0", ack_err); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", empty); end
        frame_len = 3;
        base = rx_q.size();
        wr_data = 8'h99;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        n_checks += 2;
        if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_start: got %b expected 1", tx_start); end
        if (tx_data !== 8'h99) begin n_fail++; $display("FAIL rstmid_idle_data: got %h expected 99", tx_data); end
        wait_drain(base + 1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_drain: got timeout expected frame end"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
